s_msg_sequencer: RTL and testbench
==================================

Name: s_msg_sequencer

Overview:
Controller between the SPI slave byte engine (s_spi_control) and the 64-byte message buffers on the slave board. It synchronises the engine's SCLK-domain busy flags and SS into clk and detects frame start and end. It steps the transmit pointer to feed the engine the next outgoing byte, and captures each received byte into the receive buffer. It gives the display path a registered read port and reports frame completion and overflow.

Parameters:
ADDR_W, 6, log2 of buffer depth; depth = 2**ADDR_W = 64
IDLE_BYTE, 8'h00, byte driven once tx_len bytes have been sent
SYNC_STAGES, 2, synchroniser flops on ss_n, rx_busy, tx_busy (minimum 2)

Ports:
clk  in  1  system clock
rst_btn  in  1  reset, synchronous, active-high (debounced pulse from top)
ss_n  in  1  SPI slave select, active-low, asynchronous to clk
rx_busy  in  1  engine is_receiveing; asynchronous
tx_busy  in  1  engine is_transmitting; asynchronous
rx_byte  in  8  engine i_data; stable while rx_busy low
tx_byte  out  8  to engine o_data
tx_wr_en  in  1  write strobe, tx buffer
tx_wr_addr  in  ADDR_W  tx buffer write address
tx_wr_data  in  8  tx buffer write data
tx_len  in  ADDR_W+1  valid tx bytes, 0..64
disp_addr  in  ADDR_W  display read address
disp_data  out  8  display read data, registered
rx_count  out  ADDR_W+1  bytes captured in current or last frame, 0..64
frame_done  out  1  one-cycle pulse at frame end
rx_overflow  out  1  sticky: byte arrived with buffer full

Behaviour:
- Synchronisation: ss_n, rx_busy and tx_busy each pass through SYNC_STAGES flops, then one history flop.
  - Edges are detected on the synchronised signal.
  - rx_done = rx_busy falling edge. tx_done = tx_busy falling edge.
  - ss_fall = frame start. ss_rise = frame end.
- Reset (rst_btn=1 at a clk edge), regardless of state:
  - state=IDLE; tx_byte=0, tx_ptr=1, rx_count=0.
  - frame_done=0, rx_overflow=0, disp_data=0; synchroniser flops are set to 1.
  - Buffer contents are not cleared. tx_wr_en is ignored during reset.
- Tx buffer write: when tx_wr_en=1 and rst_btn=0, tx_mem[tx_wr_addr]<=tx_wr_data. The write is independent of state.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - Every cycle: tx_byte <= (tx_len!=0) ? tx_mem[0] : IDLE_BYTE, and tx_ptr <= 1.
  - On ss_fall: rx_count<=0, rx_overflow<=0, go to ACTIVE.
- ACTIVE:
  - On tx_done: tx_byte <= (tx_ptr<tx_len) ? tx_mem[tx_ptr] : IDLE_BYTE. tx_ptr increments and saturates at 64, with no wrap.
  - On rx_done with rx_count<64: rx_mem[rx_count]<=rx_byte and rx_count++. With rx_count==64: the byte is dropped and rx_overflow<=1.
  - tx_done and rx_done in the same cycle: both actions are taken.
  - On ss_rise: go to DONE. If rx_done coincides with ss_rise, the byte is captured first.
- DONE: frame_done=1 for exactly this cycle, then go to IDLE. rx_count holds until the next ss_fall.
- frame_done is 0 in every state other than DONE.
- Display read: disp_data <= (disp_addr < rx_count) ? rx_mem[disp_addr] : 8'h00. Latency is 1 cycle.
  - Reading a location in the same cycle it is written returns the old content or 0.
- Edges outside ACTIVE are ignored (rx_done/tx_done in IDLE or DONE).
- ss_fall while in DONE is lost. The master guarantees at least SYNC_STAGES+3 clk cycles of SS high between frames.

Test Plan:
- Reset → tx_byte=0, rx_count=0, frame_done=0, rx_overflow=0. Load "SLAVE" at tx addr 0..4, tx_len=5 → tx_byte=8'h53 ('S') within 1 cycle of leaving reset.
- Frame: SS low, 3 bytes 8'h41/8'h42/8'h43 received with tx_busy pulses, SS high → tx_byte sequence 'L','A','V' after each tx_done. rx_count=3, frame_done single pulse. disp_addr 0..3 → 41,42,43,00.
- tx_len=2, 4 tx_done pulses in one frame → tx_byte 'L', then IDLE_BYTE 00, 00, 00. tx_ptr saturates with no wrap.
- 66 received bytes in one frame → rx_count=64, rx_overflow=1; disp_addr 63 holds byte #63. The next ss_fall clears rx_overflow and rx_count.
- rx_busy fall coincident with ss_rise (after synchronisation) → byte captured, rx_count incremented, then frame_done.
- rst_btn asserted mid-frame after 2 bytes → next cycle rx_count=0, state IDLE; tx_byte reloads tx_mem[0] on the following cycle. Busy edges before the next ss_fall are ignored.

Source files
------------

// File: rtl/s_msg_sequencer_if.sv
// s_msg_sequencer_if: SPI engine, tx buffer load and display signals of the message sequencer
interface s_msg_sequencer_if #(parameter int ADDR_W = 6);
    logic              ss_n;
    logic              rx_busy;
    logic              tx_busy;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic              tx_wr_en;
    logic [ADDR_W-1:0] tx_wr_addr;
    logic [7:0]        tx_wr_data;
    logic [ADDR_W:0]   tx_len;
    logic [ADDR_W-1:0] disp_addr;
    logic [7:0]        disp_data;
    logic [ADDR_W:0]   rx_count;
    logic              frame_done;
    logic              rx_overflow;
    modport master (
        output ss_n, rx_busy, tx_busy, rx_byte, tx_wr_en, tx_wr_addr, tx_wr_data, tx_len, disp_addr,
        input  tx_byte, disp_data, rx_count, frame_done, rx_overflow
    );
    modport slave (
        input  ss_n, rx_busy, tx_busy, rx_byte, tx_wr_en, tx_wr_addr, tx_wr_data, tx_len, disp_addr,
        output tx_byte, disp_data, rx_count, frame_done, rx_overflow
    );
endinterface

// File: rtl/s_msg_sequencer.sv
// s_msg_sequencer: feeds the SPI slave engine from the tx buffer and captures received bytes into the rx buffer
module s_msg_sequencer #(
    parameter int         ADDR_W      = 6,
    parameter logic [7:0] IDLE_BYTE   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_btn,
    s_msg_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];
    state_t state_q, state_d;
    logic [SYNC_STAGES:0] ss_q, ss_d, rxb_q, rxb_d, txb_q, txb_d;
    logic [7:0] tx_byte_q, tx_byte_d, disp_data_q, disp_data_d;
    logic [ADDR_W:0] tx_ptr_q, tx_ptr_d, rx_count_q, rx_count_d;
    logic frame_done_q, frame_done_d, rx_overflow_q, rx_overflow_d;
    logic ss_fall, ss_rise, rx_done, tx_done, rx_we;
    assign ss_d  = {ss_q[SYNC_STAGES-1:0], bus.ss_n};
    assign rxb_d = {rxb_q[SYNC_STAGES-1:0], bus.rx_busy};
    assign txb_d = {txb_q[SYNC_STAGES-1:0], bus.tx_busy};
    assign ss_fall = ss_q[SYNC_STAGES] & ~ss_q[SYNC_STAGES-1];
    assign ss_rise = ~ss_q[SYNC_STAGES] & ss_q[SYNC_STAGES-1];
    assign rx_done = rxb_q[SYNC_STAGES] & ~rxb_q[SYNC_STAGES-1];
    assign tx_done = txb_q[SYNC_STAGES] & ~txb_q[SYNC_STAGES-1];
    assign rx_we = (state_q == ACTIVE) && rx_done && (rx_count_q < FULL) && !rst_btn;
    assign disp_data_d = ({1'b0, bus.disp_addr} < rx_count_q) ? rx_mem[bus.disp_addr] : 8'h00;
    always_comb begin
        state_d       = state_q;
        tx_byte_d     = tx_byte_q;
        tx_ptr_d      = tx_ptr_q;
        rx_count_d    = rx_count_q;
        rx_overflow_d = rx_overflow_q;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_byte_d = (bus.tx_len != '0) ? tx_mem[0] : IDLE_BYTE;
                tx_ptr_d  = (ADDR_W + 1)'(1);
                if (ss_fall) begin
                    rx_count_d    = '0;
                    rx_overflow_d = 1'b0;
                    state_d       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (tx_done) begin
                    tx_byte_d = (tx_ptr_q < bus.tx_len) ? tx_mem[tx_ptr_q[ADDR_W-1:0]] : IDLE_BYTE;
                    tx_ptr_d  = (tx_ptr_q == FULL) ? FULL : tx_ptr_q + (ADDR_W + 1)'(1);
                end
                if (rx_done) begin
                    rx_count_d    = (rx_count_q < FULL) ? rx_count_q + (ADDR_W + 1)'(1) : rx_count_q;
                    rx_overflow_d = rx_overflow_q | (rx_count_q == FULL);
                end
                if (ss_rise) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (bus.tx_wr_en && !rst_btn) tx_mem[bus.tx_wr_addr] <= bus.tx_wr_data;
        if (rx_we) rx_mem[rx_count_q[ADDR_W-1:0]] <= bus.rx_byte;
    end
    always_ff @(posedge clk) begin
        if (rst_btn) begin
            state_q       <= IDLE;
            ss_q          <= '1;
            rxb_q         <= '1;
            txb_q         <= '1;
            tx_byte_q     <= '0;
            tx_ptr_q      <= (ADDR_W + 1)'(1);
            rx_count_q    <= '0;
            frame_done_q  <= 1'b0;
            rx_overflow_q <= 1'b0;
            disp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            ss_q          <= ss_d;
            rxb_q         <= rxb_d;
            txb_q         <= txb_d;
            tx_byte_q     <= tx_byte_d;
            tx_ptr_q      <= tx_ptr_d;
            rx_count_q    <= rx_count_d;
            frame_done_q  <= frame_done_d;
            rx_overflow_q <= rx_overflow_d;
            disp_data_q   <= disp_data_d;
        end
    end
    assign bus.tx_byte     = tx_byte_q;
    assign bus.disp_data   = disp_data_q;
    assign bus.rx_count    = rx_count_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.rx_overflow = rx_overflow_q;
endmodule

// File: tb/tb_s_msg_sequencer.sv
// tb_s_msg_sequencer: directed checks of the message sequencer against hand-computed values
module tb_s_msg_sequencer;
    logic clk = 1'b0;
    logic rst_btn;
    int checks = 0;
    int errors = 0;
    int n;
    s_msg_sequencer_if #(.ADDR_W(6)) bus();
    s_msg_sequencer #(.ADDR_W(6), .IDLE_BYTE(8'h00), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_btn(rst_btn),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic ss(input logic v);
        bus.ss_n = v;
        tick(5);
    endtask
    task automatic xfer(input logic [7:0] b, input logic do_tx);
        bus.rx_busy = 1'b1;
        bus.tx_busy = do_tx;
        tick(4);
        bus.rx_byte = b;
        bus.rx_busy = 1'b0;
        bus.tx_busy = 1'b0;
        tick(5);
    endtask
    task automatic txp();
        bus.tx_busy = 1'b1;
        tick(4);
        bus.tx_busy = 1'b0;
        tick(5);
    endtask
    task automatic end_frame(output int pulses);
        pulses = 0;
        bus.ss_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.frame_done) pulses++;
        end
    endtask
    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string tag);
        bus.disp_addr = a;
        tick(1);
        chk(tag, bus.disp_data, exp);
    endtask
    initial begin
        logic [7:0] msg [5];
        logic [7:0] exp4 [4];
        msg = '{8'h53, 8'h4C, 8'h41, 8'h56, 8'h45};
        exp4 = '{8'h4C, 8'h00, 8'h00, 8'h00};
        rst_btn = 1'b1;
        bus.ss_n = 1'b1;
        bus.rx_busy = 1'b0;
        bus.tx_busy = 1'b0;
        bus.rx_byte = 8'h00;
        bus.tx_wr_en = 1'b0;
        bus.tx_wr_addr = '0;
        bus.tx_wr_data = 8'h00;
        bus.tx_len = 7'd5;
        bus.disp_addr = '0;
        tick(3);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_rx_count", bus.rx_count, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow", bus.rx_overflow, 0);
        chk("rst_disp", bus.disp_data, 8'h00);
        rst_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.tx_wr_en = 1'b1;
            bus.tx_wr_addr = 6'(i);
            bus.tx_wr_data = msg[i];
            tick(1);
        end
        bus.tx_wr_en = 1'b0;
        tick(1);
        chk("idle_tx_byte_S", bus.tx_byte, 8'h53);
        bus.tx_len = 7'd0;
        tick(1);
        chk("idle_len0_idle_byte", bus.tx_byte, 8'h00);
        bus.tx_len = 7'd5;
        tick(1);
        ss(1'b0);
        chk("f1_start_tx_byte", bus.tx_byte, 8'h53);
        chk("f1_start_rx_count", bus.rx_count, 0);
        xfer(8'h41, 1'b1);
        chk("f1_tx_L", bus.tx_byte, 8'h4C);
        xfer(8'h42, 1'b1);
        chk("f1_tx_A", bus.tx_byte, 8'h41);
        xfer(8'h43, 1'b1);
        chk("f1_tx_V", bus.tx_byte, 8'h56);
        chk("f1_rx_count_active", bus.rx_count, 3);
        chk("f1_no_done_active", bus.frame_done, 0);
        end_frame(n);
        chk("f1_done_pulses", n, 1);
        chk("f1_rx_count_hold", bus.rx_count, 3);
        chk("f1_idle_reload_S", bus.tx_byte, 8'h53);
        rd(6'd0, 8'h41, "f1_disp0");
        rd(6'd1, 8'h42, "f1_disp1");
        rd(6'd2, 8'h43, "f1_disp2");
        rd(6'd3, 8'h00, "f1_disp3_beyond");
        bus.tx_len = 7'd2;
        tick(2);
        ss(1'b0);
        chk("f2_rx_count_cleared", bus.rx_count, 0);
        for (int i = 0; i < 4; i++) begin
            txp();
            chk($sformatf("f2_tx_%0d", i), bus.tx_byte, exp4[i]);
        end
        chk("f2_rx_count_tx_only", bus.rx_count, 0);
        end_frame(n);
        chk("f2_done_pulses", n, 1);
        bus.tx_len = 7'd5;
        tick(2);
        ss(1'b0);
        for (int i = 0; i < 64; i++) xfer(8'(i + 16), 1'b0);
        chk("f3_count_64", bus.rx_count, 64);
        chk("f3_no_ovf_at_64", bus.rx_overflow, 0);
        xfer(8'hEE, 1'b0);
        xfer(8'hEF, 1'b0);
        chk("f3_count_sat", bus.rx_count, 64);
        chk("f3_ovf", bus.rx_overflow, 1);
        end_frame(n);
        chk("f3_done_pulses", n, 1);
        chk("f3_ovf_sticky", bus.rx_overflow, 1);
        rd(6'd63, 8'h4F, "f3_disp63");
        rd(6'd0, 8'h10, "f3_disp0");
        ss(1'b0);
        chk("f4_ovf_cleared", bus.rx_overflow, 0);
        chk("f4_count_cleared", bus.rx_count, 0);
        rd(6'd0, 8'h00, "f4_disp0_empty");
        bus.rx_busy = 1'b1;
        tick(4);
        bus.rx_byte = 8'h99;
        bus.rx_busy = 1'b0;
        end_frame(n);
        chk("f4_coincident_done", n, 1);
        chk("f4_coincident_count", bus.rx_count, 1);
        rd(6'd0, 8'h99, "f4_coincident_byte");
        ss(1'b0);
        xfer(8'hA1, 1'b1);
        xfer(8'hA2, 1'b1);
        chk("f5_count_2", bus.rx_count, 2);
        chk("f5_tx_A", bus.tx_byte, 8'h41);
        rst_btn = 1'b1;
        bus.ss_n = 1'b1;
        tick(1);
        chk("f5_rst_count", bus.rx_count, 0);
        chk("f5_rst_tx_byte", bus.tx_byte, 8'h00);
        rst_btn = 1'b0;
        tick(1);
        chk("f5_reload_S", bus.tx_byte, 8'h53);
        xfer(8'h77, 1'b1);
        chk("f5_idle_rx_ignored", bus.rx_count, 0);
        chk("f5_idle_tx_ignored", bus.tx_byte, 8'h53);
        chk("f5_idle_no_done", bus.frame_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
